// File: rtl/dmem_responder.sv
// Single-port 64-bit data memory responder: valid/ready request, fixed wait states, held response.
// state | meaning
// IDLE  | ready for a request
// WAIT  | counting wait states for the accepted request
// RESP  | response held until rsp_ready
module dmem_responder #(
  parameter int DEPTH       = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [7:0]  req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);
  localparam logic [5:0] DEPTH_L   = 6'(DEPTH);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [7:0]  addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [63:0] mem_q [DEPTH];

  logic        cur_write;
  logic [7:0]  cur_addr;
  logic [63:0] cur_wdata;
  logic [4:0]  cur_idx;
  logic        cur_err;
  logic [63:0] rd_word;
  logic        enter_resp;
  logic        mem_we;

  // With zero wait states RESP is entered on the acceptance edge, so the live inputs are used.
  always_comb begin
    cur_write = (state_q == IDLE) ? req_write : write_q;
    cur_addr  = (state_q == IDLE) ? req_addr  : addr_q;
    cur_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
    cur_idx   = cur_addr[7:3];
    cur_err   = (cur_addr[2:0] != 3'd0) || ({1'b0, cur_idx} >= DEPTH_L);
    rd_word   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (cur_idx == 5'(i)) rd_word = mem_q[i];
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    write_d    = write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (WAIT_CYCLES == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (enter_resp) begin
      err_d   = cur_err;
      rdata_d = (cur_err || cur_write) ? 64'd0 : rd_word;
    end
  end

  assign mem_we    = enter_resp && cur_write && !cur_err;
  assign req_ready = (state_q == IDLE) && rst_n;
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (cur_idx == 5'(i)) mem_q[i] <= cur_wdata;
      end
    end
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH, default 32, number of 64-bit memory words.
REQ-002 Parameter WAIT_CYCLES, default 2, number of wait-state cycles between request acceptance and response (range 0..15).
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port req_valid  input  1  initiator presents a request.
REQ-006 Port req_ready  output  1  responder can accept a request this cycle.
REQ-007 Port req_write  input  1  1 = store, 0 = load.
REQ-008 Port req_addr  input  8  byte address.
REQ-009 Port req_wdata  input  64  store data.
REQ-010 Port rsp_valid  output  1  response is present.
REQ-011 Port rsp_ready  input  1  initiator accepts the response.
REQ-012 Port rsp_rdata  output  64  load data; 0 for stores and errors.
REQ-013 Port rsp_err  output  1  request was misaligned or out of range.

Function
REQ-014 The block SHALL implement three states: IDLE, WAIT, RESP.
REQ-015 req_ready SHALL be 1 only in IDLE; rsp_valid SHALL be 1 only in RESP.
REQ-016 A request SHALL be accepted on the edge where req_valid and req_ready are both 1; req_write, req_addr and req_wdata SHALL be registered on that edge.
REQ-017 On acceptance: WAIT_CYCLES > 0 -> WAIT with wait counter loaded to WAIT_CYCLES-1; WAIT_CYCLES = 0 -> directly to RESP.
REQ-018 In WAIT the counter SHALL decrement each cycle; WAIT -> RESP on the edge where the counter is 0.
REQ-019 rsp_valid SHALL therefore first assert WAIT_CYCLES+1 cycles after the acceptance edge.
REQ-020 Word index SHALL be addr[7:3]; a request is an error if addr[2:0] != 0 or word index >= DEPTH.
REQ-021 Store with no error SHALL write the registered wdata into the indexed word on the edge entering RESP.
REQ-022 Load with no error SHALL capture the indexed word into rsp_rdata on the edge entering RESP.
REQ-023 Errored requests SHALL set rsp_err = 1, rsp_rdata = 0 and SHALL NOT modify memory.
REQ-024 rsp_rdata and rsp_err SHALL stay stable while in RESP until the response is accepted.
REQ-025 RESP -> IDLE on the edge where rsp_ready = 1; rsp_rdata and rsp_err SHALL then clear to 0.
REQ-026 A new request SHALL NOT be accepted on the same edge a response is accepted; req_ready rises the cycle after.
REQ-027 req_valid changes outside IDLE SHALL be ignored.
REQ-028 A load following a store to the same word SHALL return the stored data.

Reset
REQ-029 rst_n = 0 SHALL immediately force state IDLE, wait counter 0, req_ready = 1 once rst_n deasserts (0 while asserted), rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, and all memory words to 0.
REQ-030 Reset asserted in WAIT or RESP SHALL abort the transaction; a pending store SHALL NOT be written.
REQ-031 The first acceptance SHALL occur no earlier than the first rising edge after rst_n deasserts.

Verification
REQ-032 Store 0xDEADBEEF_CAFEF00D at addr 0x10, WAIT_CYCLES=2, rsp_ready=1 -> rsp_valid at acceptance+3, rsp_err=0, rsp_rdata=0; load addr 0x10 -> rsp_rdata=0xDEADBEEF_CAFEF00D.
REQ-033 Load addr 0x13 -> rsp_err=1, rsp_rdata=0; a later load at 0x10 returns the unchanged value.
REQ-034 Load addr 0xF8 with DEPTH=16 -> rsp_err=1; with DEPTH=32 -> rsp_err=0 and rsp_rdata=0 after reset.
REQ-035 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_rdata, rsp_err stable and req_ready=0; release -> IDLE, req_ready=1 one cycle later.
REQ-036 WAIT_CYCLES=0: store then load at addr 0x08 -> each rsp_valid one cycle after acceptance, load returns the stored data.
REQ-037 Assert rst_n=0 mid-WAIT of a store to 0x20 -> outputs clear immediately; a load of 0x20 after reset returns 0.
